// File: rtl/sram_pkg.sv
// Shared types and constants for the BaseRAM sequencer/arbiter.
package sram_pkg;

    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    localparam logic [31:0] BASE_RAM_LO = 32'h8000_0000;
    localparam logic [31:0] BASE_RAM_HI = 32'h8040_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Access latched at grant time and held for the whole SRAM cycle.
    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [BE_W-1:0]    be_n;
        logic [DATA_W-1:0]  wdata;
        logic               we_n;
        gnt_e               gnt;
    } sram_req_t;

    // True when a byte address falls inside the BaseRAM window.
    function automatic logic is_base_ram(input logic [31:0] addr);
        return (addr >= BASE_RAM_LO) && (addr < BASE_RAM_HI);
    endfunction

    // SRAM word address taken from a byte address.
    function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] addr);
        return addr[21:2];
    endfunction

endpackage

// File: rtl/base_ram_arbiter_if.sv
// Requester handshakes plus SRAM pin bundle for the BaseRAM arbiter.
interface base_ram_arbiter_if;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;

    logic        mem_req_i;
    logic        mem_we_n_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;

    logic        stall_o;

    logic [19:0] sram_addr_o;
    logic [3:0]  sram_be_n_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [31:0] sram_wdata_o;
    logic        sram_data_oe_o;
    logic [31:0] sram_rdata_i;

    // Pipeline / pad side.
    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_n_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        output sram_rdata_i,
        input  if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, stall_o,
        input  sram_addr_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        input  sram_wdata_o, sram_data_oe_o
    );

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_n_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        input  sram_rdata_i,
        output if_ack_o, if_data_o, mem_ack_o, mem_rdata_o, stall_o,
        output sram_addr_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        output sram_wdata_o, sram_data_oe_o
    );

endinterface

// File: rtl/sram_phase_timer.sv
// Loadable down-counter; done is registered and high once the count reaches zero.
module sram_phase_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Reload on state entry, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            done  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
            done  <= (count == WIDTH'(1));
        end
    end

endmodule

// File: rtl/base_ram_arbiter.sv
// Arbitrates fetch vs data access onto the BaseRAM port and sequences the SRAM cycle.
module base_ram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk_50M,
    input  logic                rst,
    base_ram_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1) + 1;

    state_e            state, state_d;
    gnt_e              last_grant, last_grant_d;
    sram_req_t         req_q, req_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              doe_q, doe_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic              pick_mem;
    logic              tmr_load, tmr_done;
    logic [CNT_W-1:0]  tmr_val;

    sram_phase_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk_50M),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State, latched access and all pad/ack/data registers.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GNT_IF;
            req_q       <= '{addr: '0, be_n: '1, wdata: '0, we_n: 1'b1, gnt: GNT_IF};
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            doe_q       <= 1'b0;
            be_n_q      <= '1;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            req_q       <= req_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            doe_q       <= doe_d;
            be_n_q      <= be_n_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next state plus pad controls derived from the state being entered.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        req_d        = req_q;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        doe_d        = 1'b0;
        be_n_d       = '1;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        pick_mem     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.if_req_i || bus.mem_req_i) begin
                    // Data wins a tie unless it won the previous grant.
                    pick_mem = bus.mem_req_i && (!bus.if_req_i || (last_grant != GNT_MEM));
                    if (pick_mem) begin
                        req_d.addr  = word_addr(bus.mem_addr_i);
                        req_d.be_n  = bus.mem_sel_i;
                        req_d.wdata = bus.mem_wdata_i;
                        req_d.we_n  = bus.mem_we_n_i;
                        req_d.gnt   = GNT_MEM;
                    end else begin
                        req_d.addr  = word_addr(bus.if_addr_i);
                        req_d.be_n  = '0;
                        req_d.we_n  = 1'b1;
                        req_d.gnt   = GNT_IF;
                    end
                    last_grant_d = req_d.gnt;
                    state_d      = req_d.we_n ? RD : WR_SETUP;
                    tmr_load     = 1'b1;
                    tmr_val      = req_d.we_n ? CNT_W'(WAIT_CYCLES) : '0;
                end
            end
            RD: begin
                if (tmr_done) begin
                    if (req_q.gnt == GNT_MEM) mem_rdata_d = bus.sram_rdata_i;
                    else                      if_data_d   = bus.sram_rdata_i;
                    state_d  = ACK;
                    tmr_load = 1'b1;
                end
            end
            WR_SETUP: begin
                state_d  = WR_PULSE;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(WAIT_CYCLES - 1);
            end
            WR_PULSE: begin
                if (tmr_done) begin
                    state_d  = WR_HOLD;
                    tmr_load = 1'b1;
                end
            end
            WR_HOLD: begin
                state_d  = ACK;
                tmr_load = 1'b1;
            end
            ACK: begin
                state_d  = IDLE;
                tmr_load = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ACK) begin
            if_ack_d  = (req_d.gnt == GNT_IF);
            mem_ack_d = (req_d.gnt == GNT_MEM);
        end

        case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = req_d.be_n;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d = 1'b0;
                doe_d  = 1'b1;
                be_n_d = req_d.be_n;
            end
            WR_PULSE: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                doe_d  = 1'b1;
                be_n_d = req_d.be_n;
            end
            default: ;
        endcase
    end

    assign bus.sram_addr_o    = req_q.addr;
    assign bus.sram_wdata_o   = req_q.wdata;
    assign bus.sram_be_n_o    = be_n_q;
    assign bus.sram_ce_n_o    = ce_n_q;
    assign bus.sram_oe_n_o    = oe_n_q;
    assign bus.sram_we_n_o    = we_n_q;
    assign bus.sram_data_oe_o = doe_q;
    assign bus.if_ack_o       = if_ack_q;
    assign bus.if_data_o      = if_data_q;
    assign bus.mem_ack_o      = mem_ack_q;
    assign bus.mem_rdata_o    = mem_rdata_q;

    // Stall while either request is waiting for its ack.
    assign bus.stall_o = (bus.if_req_i & ~if_ack_q) | (bus.mem_req_i & ~mem_ack_q);

endmodule
